// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared state type, channel indices and defaults for the ADC frame sequencer
package adc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_QUIET
    } seq_state_t;

    localparam int CH_CI  = 0;
    localparam int CH_CV  = 1;
    localparam int CH_LI  = 2;
    localparam int CH_LV  = 3;
    localparam int NUM_CH = 4;

    localparam int DEF_DATA_W    = 12;
    localparam int DEF_LEAD_BITS = 2;
    localparam int DEF_FRAME_LEN = 16;
    localparam int DEF_QUIET     = 2;
    localparam int DEF_PERIOD_W  = 16;

endpackage

// File: rtl/adc_lane_shift.sv
// rtl/adc_lane_shift.sv - MSB-first serial-to-parallel shifter for one ADC lane
module adc_lane_shift #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              shift_en,
    input  logic              sdata,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] sh;

    // word already contains the bit being shifted this cycle, so a frame whose
    // last low cycle carries the LSB is still captured complete
    assign word = shift_en ? {sh[DATA_W-2:0], sdata} : sh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh <= '0;
        end else if (shift_en) begin
            sh <= word;
        end
    end

endmodule

// File: rtl/adc_frame_sequencer.sv
// rtl/adc_frame_sequencer.sv - schedules ADC frames, drives ad_cs and deserialises four lanes
module adc_frame_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEAD_BITS = DEF_LEAD_BITS,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int QUIET     = DEF_QUIET,
    parameter int PERIOD_W  = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                trig,
    output logic                ad_cs,
    input  logic [1:0]          ad_sdata_a,
    input  logic [1:0]          ad_sdata_b,
    output logic [DATA_W-1:0]   sample_ci,
    output logic [DATA_W-1:0]   sample_cv,
    output logic [DATA_W-1:0]   sample_li,
    output logic [DATA_W-1:0]   sample_lv,
    output logic                sample_valid,
    output logic                busy,
    output logic [7:0]          overrun_cnt,
    output logic [15:0]         frame_cnt
);

    localparam int CNT_MAX = (FRAME_LEN > QUIET) ? FRAME_LEN : QUIET;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]    CONV_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]    QUIET_LAST = CNT_W'(QUIET - 1);
    localparam logic [CNT_W-1:0]    SHIFT_LO   = CNT_W'(LEAD_BITS);
    localparam logic [CNT_W-1:0]    SHIFT_HI   = CNT_W'(LEAD_BITS + DATA_W - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(FRAME_LEN + QUIET);

    seq_state_t          state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                pending, pending_next;
    logic [PERIOD_W-1:0] timer, eff_period;
    logic                enable_q, en_rise, en_fall, timer_fire, req;
    logic                start, ovr_inc, frame_done, shift_en;
    logic [NUM_CH-1:0]   lane_bit;
    logic [DATA_W-1:0]   lane_word [NUM_CH];

    assign en_rise    = enable & ~enable_q;
    assign en_fall    = ~enable & enable_q;
    assign timer_fire = enable & enable_q & (timer == '0);
    assign req        = en_rise | timer_fire | trig;
    assign eff_period = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    assign shift_en   = (state == ST_CONV) && (cnt >= SHIFT_LO) && (cnt <= SHIFT_HI);
    assign busy       = (state != ST_IDLE);

    assign lane_bit[CH_CI] = ad_sdata_a[0];
    assign lane_bit[CH_CV] = ad_sdata_a[1];
    assign lane_bit[CH_LI] = ad_sdata_b[0];
    assign lane_bit[CH_LV] = ad_sdata_b[1];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        adc_lane_shift #(.DATA_W(DATA_W)) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .shift_en (shift_en),
            .sdata    (lane_bit[g]),
            .word     (lane_word[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            timer    <= '0;
        end else begin
            enable_q <= enable;
            if (!enable) begin
                timer <= '0;
            end else if (en_rise || timer == '0) begin
                timer <= eff_period - PERIOD_W'(1);
            end else begin
                timer <= timer - PERIOD_W'(1);
            end
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        start        = 1'b0;
        ovr_inc      = 1'b0;
        frame_done   = 1'b0;
        case (state)
            ST_IDLE:  start = req | pending;
            ST_CONV: begin
                if (cnt == CONV_LAST) begin
                    state_next = ST_QUIET;
                    cnt_next   = '0;
                    frame_done = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_QUIET: begin
                if (cnt == QUIET_LAST) begin
                    state_next = ST_IDLE;
                    start      = req | pending;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default:  state_next = ST_IDLE;
        endcase
        if (start) begin
            state_next = ST_CONV;
            cnt_next   = '0;
        end
        // one-deep pending: a request that finds it already full is lost
        if (req) begin
            if (pending) begin
                ovr_inc = 1'b1;
            end else if (!start) begin
                pending_next = 1'b1;
            end
        end
        if (start || en_fall) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pending      <= 1'b0;
            ad_cs        <= 1'b1;
            sample_ci    <= '0;
            sample_cv    <= '0;
            sample_li    <= '0;
            sample_lv    <= '0;
            sample_valid <= 1'b0;
            overrun_cnt  <= '0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            pending      <= pending_next;
            ad_cs        <= (state_next != ST_CONV);
            sample_valid <= frame_done;
            if (frame_done) begin
                sample_ci <= lane_word[CH_CI];
                sample_cv <= lane_word[CH_CV];
                sample_li <= lane_word[CH_LI];
                sample_lv <= lane_word[CH_LV];
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (ovr_inc && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb/tb_adc_frame_sequencer.sv - scoreboard bench for adc_frame_sequencer with a behavioural ADC model
`timescale 1ns/1ps
module tb_adc_frame_sequencer;
    import adc_seq_pkg::*;

    localparam int DW   = 12;
    localparam int LEAD = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          trig = 1'b0;
    logic [15:0]   period = '0;
    logic          ad_cs;
    logic [1:0]    ad_sdata_a = '0;
    logic [1:0]    ad_sdata_b = '0;
    logic [DW-1:0] sample_ci, sample_cv, sample_li, sample_lv;
    logic          sample_valid, busy;
    logic [7:0]    overrun_cnt;
    logic [15:0]   frame_cnt;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int vcount = 0;
    int adc_k = 0;
    int v0;
    logic          prev_cs = 1'b1;
    logic [DW-1:0] adc_val [4];
    logic [4*DW-1:0] exp_q [$];
    logic [4*DW-1:0] e;
    int fall_q [$];

    adc_frame_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .period       (period),
        .trig         (trig),
        .ad_cs        (ad_cs),
        .ad_sdata_a   (ad_sdata_a),
        .ad_sdata_b   (ad_sdata_b),
        .sample_ci    (sample_ci),
        .sample_cv    (sample_cv),
        .sample_li    (sample_li),
        .sample_lv    (sample_lv),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // lead bits 0, data MSB first, trailing bits 1 so stray shifts are visible
    function automatic logic adc_bit(input logic [DW-1:0] v, input int k);
        if (k < LEAD) return 1'b0;
        if (k < LEAD + DW) return v[DW-1-(k-LEAD)];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (ad_cs !== 1'b0) begin
            adc_k      = 0;
            ad_sdata_a = 2'b00;
            ad_sdata_b = 2'b00;
        end else begin
            ad_sdata_a = {adc_bit(adc_val[CH_CV], adc_k), adc_bit(adc_val[CH_CI], adc_k)};
            ad_sdata_b = {adc_bit(adc_val[CH_LV], adc_k), adc_bit(adc_val[CH_LI], adc_k)};
            adc_k++;
        end
        if (prev_cs === 1'b1 && ad_cs === 1'b0) fall_q.push_back(cyc);
        prev_cs = ad_cs;
    end

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            vcount++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sample_ci", sample_ci, e[4*DW-1 -: DW]);
                check("sample_cv", sample_cv, e[3*DW-1 -: DW]);
                check("sample_li", sample_li, e[2*DW-1 -: DW]);
                check("sample_lv", sample_lv, e[DW-1 -: DW]);
            end
        end
    end

    task automatic load(input logic [DW-1:0] ci, input logic [DW-1:0] cv,
                        input logic [DW-1:0] li, input logic [DW-1:0] lv, input int n);
        adc_val[CH_CI] = ci;
        adc_val[CH_CV] = cv;
        adc_val[CH_LI] = li;
        adc_val[CH_LV] = lv;
        for (int i = 0; i < n; i++) exp_q.push_back({ci, cv, li, lv});
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic check_frames(input string nm, input int n, input int gap);
        check({nm, "_frames"}, fall_q.size(), n);
        for (int i = 1; i < fall_q.size(); i++)
            check({nm, "_gap"}, fall_q[i] - fall_q[i-1], gap);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) adc_val[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ad_cs", ad_cs, 1);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_samples", {sample_ci, sample_cv, sample_li, sample_lv}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single trig: cs low in cycles 1..16, valid in 17, idle from 19
        load(12'hABC, 12'h123, 12'hFFF, 12'h000, 1);
        pulse_trig();
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            check($sformatf("t1_cs_c%0d", n), ad_cs, (n <= 16) ? 1'b0 : 1'b1);
            if (n >= 16 && n <= 18) check($sformatf("t1_valid_c%0d", n), sample_valid, n == 17);
            if (n == 17) check("t1_frame_cnt", frame_cnt, 1);
            if (n == 18) check("t1_busy_c18", busy, 1);
            if (n == 19) check("t1_busy_c19", busy, 0);
        end

        // periodic, period 20: five frames
        fall_q.delete();
        v0 = vcount;
        load(12'h5A5, 12'h3C3, 12'h001, 12'h800, 5);
        @(negedge clk);
        period = 16'd20;
        enable = 1'b1;
        repeat (90) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check_frames("t2", 5, 20);
        check("t2_valids", vcount - v0, 5);
        check("t2_overrun", overrun_cnt, 0);
        check("t2_frame_cnt", frame_cnt, 6);

        // period below minimum is clamped to 18
        fall_q.delete();
        v0 = vcount;
        load(12'h7FF, 12'h800, 12'hAAA, 12'h555, 4);
        @(negedge clk);
        period = 16'd5;
        enable = 1'b1;
        repeat (60) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check_frames("t3", 4, 18);
        check("t3_valids", vcount - v0, 4);
        check("t3_overrun", overrun_cnt, 0);
        check("t3_frame_cnt", frame_cnt, 10);

        // period 18 with trig every 3 cycles: 5 + 5 + 2 dropped requests
        fall_q.delete();
        v0 = vcount;
        load(12'h0F0, 12'hF0F, 12'h123, 12'h321, 3);
        period = 16'd18;
        for (int ed = 0; ed <= 60; ed++) begin
            @(negedge clk);
            enable = (ed < 48);
            trig   = (ed > 0 && ed <= 45 && ed % 3 == 0);
        end
        trig = 1'b0;
        repeat (30) @(negedge clk);
        check_frames("t4", 3, 18);
        check("t4_valids", vcount - v0, 3);
        check("t4_overrun", overrun_cnt, 12);
        check("t4_frame_cnt", frame_cnt, 13);

        // enable dropped at CONV bit 7: frame completes, nothing follows
        fall_q.delete();
        v0 = vcount;
        load(12'h9E7, 12'h18C, 12'h6B2, 12'h4D4, 1);
        period = 16'd40;
        @(negedge clk);
        enable = 1'b1;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        repeat (60) @(negedge clk);
        check_frames("t5", 1, 0);
        check("t5_valids", vcount - v0, 1);
        check("t5_frame_cnt", frame_cnt, 14);
        check("t5_busy", busy, 0);
        check("t5_overrun", overrun_cnt, 12);

        // reset at CONV bit 9: partial frame yields nothing
        v0 = vcount;
        load(12'hC35, 12'h0A1, 12'h777, 12'h888, 0);
        pulse_trig();
        repeat (9) @(negedge clk);
        check("t6_cs_before", ad_cs, 0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_cs", ad_cs, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_frame_cnt", frame_cnt, 0);
        check("t6_rst_overrun", overrun_cnt, 0);
        check("t6_rst_samples", {sample_ci, sample_cv, sample_li, sample_lv}, 0);
        check("t6_rst_valid", sample_valid, 0);
        repeat (20) @(negedge clk);
        check("t6_no_valid", vcount - v0, 0);
        reset_n = 1'b1;
        load(12'hC35, 12'h0A1, 12'h777, 12'h888, 1);
        pulse_trig();
        repeat (25) @(negedge clk);
        check("t6_valids", vcount - v0, 1);
        check("t6_frame_cnt", frame_cnt, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
